pdm_audio_feeder: RTL and testbench



---
 rtl/pdm_audio_pkg.sv | 17 +
 rtl/pdm_gain_sat.sv | 35 +++
 rtl/pdm_audio_feeder.sv | 128 ++++++++++++
 tb/tb_pdm_audio_feeder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_audio_pkg.sv
// Shared types for the PDM audio output path: feeder FSM states and gain helpers.
// Optional build macro used by the feeder: PDM_FEED_STATS_EN (underrun counter).
package pdm_audio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_PLAY    = 2'd2,
      ST_REFILL  = 2'd3
   } state_e;

   // Gain code that reproduces the input sample exactly (2^(GW-1)).
   function automatic int unsigned unity_gain(input int unsigned gw);
      return 32'd1 << (gw - 1);
   endfunction

endpackage

// File: rtl/pdm_gain_sat.sv
// One channel of gain: signed sample times unsigned gain, scaled by 2^-(GW-1),
// clamped to the W-bit two's complement range. Purely combinational.
module pdm_gain_sat #(
   parameter int W  = 16,
   parameter int GW = 8
) (
   input  logic [W-1:0]  sample_i,
   input  logic [GW-1:0] gain_i,
   output logic [W-1:0]  y_o
);

   localparam int PW = W + GW + 1;

   logic signed [PW-1:0] s_ext;
   logic signed [PW-1:0] g_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;

   assign s_ext   = {{(GW + 1){sample_i[W-1]}}, sample_i};
   assign g_ext   = {{(W + 1){1'b0}}, gain_i};
   assign prod    = s_ext * g_ext;
   assign shifted = prod >>> (GW - 1);

   // The value fits when every bit above the result's sign bit repeats it.
   always_comb begin
      if (shifted[PW-1:W-1] == {(PW - W + 1){shifted[PW-1]}}) begin
         y_o = shifted[W-1:0];
      end else if (shifted[PW-1]) begin
         y_o = {1'b1, {(W - 1){1'b0}}};
      end else begin
         y_o = {1'b0, {(W - 1){1'b1}}};
      end
   end

endmodule

// File: rtl/pdm_audio_feeder.sv
// Sample-rate FIFO reader for the PDM path: prefill/underrun recovery, per-channel
// gain with saturation and mute. Define PDM_FEED_STATS_EN to add underrun_cnt.
module pdm_audio_feeder
   import pdm_audio_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int W       = 16,
   parameter int GW      = 8,
   parameter int LVL_W   = 10,
   parameter int PREFILL = 64
) (
   input  logic                rdclk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                rdempty,
   input  logic [LVL_W-1:0]    rd_level,
   output logic                rden,
   input  logic [NCH*W-1:0]    rddat,
   input  logic [NCH*GW-1:0]   gain,
   input  logic                mute,
   output logic [NCH*W-1:0]    sample_out,
   output logic                sample_vld,
   output logic [1:0]          state,
   output logic                underrun
`ifdef PDM_FEED_STATS_EN
   ,
   output logic [15:0]         underrun_cnt
`endif
);

   localparam logic [LVL_W:0] PRE_LVL = (LVL_W + 1)'(PREFILL);

   // Handshake: rden=1 in cycle N pops one word; the FIFO presents it on rddat
   // during cycle N+1 (its output register is pipeline stage 1, tracked by v1_q).
   state_e             state_q, state_d;
   logic               v1_q, v1_d;
   logic [NCH*W-1:0]   sample_out_q, sample_out_d;
   logic               sample_vld_q, sample_vld_d;
   logic [NCH*W-1:0]   gained;
   logic               level_ok;
   logic               flush;

   assign level_ok = ({1'b0, rd_level} >= PRE_LVL) && !rdempty;

   always_comb begin
      state_d  = state_q;
      rden     = 1'b0;
      underrun = 1'b0;
      case (state_q)
         ST_IDLE:               state_d = ST_PREFILL;
         ST_PREFILL, ST_REFILL: if (level_ok) state_d = ST_PLAY;
         ST_PLAY: begin
            rden     = !rdempty && enable;
            underrun = rdempty && enable;
            if (rdempty) state_d = ST_REFILL;
         end
         default:               state_d = ST_IDLE;
      endcase
      if (!enable) state_d = ST_IDLE;
      // Leaving playback silences the output and drops the word in flight.
      flush = (state_d == ST_IDLE) || (state_d == ST_REFILL);
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      pdm_gain_sat #(
         .W  (W),
         .GW (GW)
      ) u_gain (
         .sample_i (rddat[k*W +: W]),
         .gain_i   (gain[k*GW +: GW]),
         .y_o      (gained[k*W +: W])
      );
   end

   always_comb begin
      v1_d         = rden && !flush;
      sample_out_d = sample_out_q;
      sample_vld_d = 1'b0;
      if (flush) begin
         sample_out_d = '0;
      end else if (mute) begin
         sample_out_d = '0;
         sample_vld_d = v1_q;
      end else if (v1_q) begin
         sample_out_d = gained;
         sample_vld_d = 1'b1;
      end
   end

   always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         v1_q         <= 1'b0;
         sample_out_q <= '0;
         sample_vld_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         v1_q         <= v1_d;
         sample_out_q <= sample_out_d;
         sample_vld_q <= sample_vld_d;
      end
   end

   assign state      = state_q;
   assign sample_out = sample_out_q;
   assign sample_vld = sample_vld_q;

`ifdef PDM_FEED_STATS_EN
   logic [15:0] ucnt_q, ucnt_d;

   always_comb begin
      ucnt_d = ucnt_q;
      if (state_d == ST_IDLE) begin
         ucnt_d = '0;
      end else if (underrun && (ucnt_q != 16'hFFFF)) begin
         ucnt_d = ucnt_q + 16'd1;
      end
   end

   always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) ucnt_q <= '0;
      else        ucnt_q <= ucnt_d;
   end

   assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_pdm_audio_feeder.sv
// Directed/random bench for pdm_audio_feeder with a FIFO model and arithmetic
// gain reference. Covers PDM_FEED_STATS_EN when that macro is defined.
module tb_pdm_audio_feeder;
   import pdm_audio_pkg::*;

   localparam int NCH   = 2;
   localparam int W     = 16;
   localparam int GW    = 8;
   localparam int LVL_W = 10;
   localparam int PRE   = 64;
   localparam longint UNITY = longint'(unity_gain(GW));

   logic                rdclk;
   logic                rst_n;
   logic                enable;
   logic                rdempty;
   logic [LVL_W-1:0]    rd_level;
   logic                rden;
   logic [NCH*W-1:0]    rddat;
   logic [NCH*GW-1:0]   gain;
   logic                mute;
   logic [NCH*W-1:0]    sample_out;
   logic                sample_vld;
   logic [1:0]          state;
   logic                underrun;
`ifdef PDM_FEED_STATS_EN
   logic [15:0]         underrun_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   logic [NCH*W-1:0] exp_q[$];
   logic [NCH*W-1:0] src_q[$];
   logic [NCH*W-1:0] exp_out;
   logic [NCH*GW-1:0] g_edge;
   logic             m_edge;
   logic             sb_on;

   pdm_audio_feeder #(
      .NCH (NCH), .W (W), .GW (GW), .LVL_W (LVL_W), .PREFILL (PRE)
   ) dut (
      .rdclk      (rdclk),
      .rst_n      (rst_n),
      .enable     (enable),
      .rdempty    (rdempty),
      .rd_level   (rd_level),
      .rden       (rden),
      .rddat      (rddat),
      .gain       (gain),
      .mute       (mute),
      .sample_out (sample_out),
      .sample_vld (sample_vld),
      .state      (state),
      .underrun   (underrun)
`ifdef PDM_FEED_STATS_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   initial rdclk = 1'b0;
   always #5 rdclk = ~rdclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   // Reference gain: floor(sample*gain / unity), clamped, zero when muted.
   function automatic logic [NCH*W-1:0] ref_out(input logic [NCH*W-1:0] w,
                                                 input logic [NCH*GW-1:0] g,
                                                 input logic m);
      logic [NCH*W-1:0] r;
      longint s, gg, p, y;
      r = '0;
      for (int k = 0; k < NCH; k++) begin
         s  = longint'($signed(w[k*W +: W]));
         gg = longint'(g[k*GW +: GW]);
         p  = s * gg;
         if (p >= 0) y = p / UNITY;
         else        y = -((-p + UNITY - 1) / UNITY);
         if (y > 32767)  y = 32767;
         if (y < -32768) y = -32768;
         if (m) y = 0;
         r[k*W +: W] = y[W-1:0];
      end
      return r;
   endfunction

   // One sample period: FIFO model serves reads at the edge, scoreboard checks
   // outputs at the falling edge. flush=1 marks a cycle that leaves playback.
   task automatic cyc(input bit flush = 1'b0);
      logic [NCH*W-1:0] w;
      bit rd;
      @(posedge rdclk);
      g_edge = gain;
      m_edge = mute;
      rd     = rden;
      #1;
      if (rd) begin
         if (src_q.size() > 0) w = src_q.pop_front();
         else                  w = $urandom;
         rddat = w;
         exp_q.push_back(w);
      end
      if (flush) begin
         exp_q.delete();
         exp_out = '0;
      end
      @(negedge rdclk);
      if (rst_n && sb_on) begin
         if (sample_vld) begin
            if (exp_q.size() == 0) begin
               chk("sb_extra_vld", 32'(sample_vld), 32'd0);
            end else begin
               w       = exp_q.pop_front();
               exp_out = ref_out(w, g_edge, m_edge);
               chk("sb_sample", sample_out, exp_out);
            end
         end else begin
            chk("sb_hold", sample_out, exp_out);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      enable   = 1'b0;
      rdempty  = 1'b1;
      rd_level = '0;
      mute     = 1'b0;
      gain     = {8'd128, 8'd128};
      rddat    = '0;
      sb_on    = 1'b0;
      exp_out  = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_rden", 32'(rden), 32'd0);
      chk("rst_sample_out", sample_out, 32'd0);
      chk("rst_sample_vld", 32'(sample_vld), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      #20 rst_n = 1'b1;
      @(negedge rdclk);
      sb_on = 1'b1;

      // Prefill: level ramps up, 63 with data present must not start playback.
      src_q.push_back({16'h8000, 16'h7FFF});
      enable = 1'b1;
      cyc();
      chk("enter_prefill", 32'(state), 32'd1);
      for (int lvl = 0; lvl <= 63; lvl += 16) begin
         rd_level = LVL_W'((lvl == 48) ? 63 : lvl);
         rdempty  = (lvl != 48);
         cyc();
         chk("prefill_state", 32'(state), 32'd1);
         chk("prefill_rden", 32'(rden), 32'd0);
      end
      rd_level = LVL_W'(PRE);
      rdempty  = 1'b0;
      #1 chk("prefill_no_rden_yet", 32'(rden), 32'd0);
      cyc();
      chk("play_state", 32'(state), 32'd2);
      chk("first_rden", 32'(rden), 32'd1);
      chk("vld_lat0", 32'(sample_vld), 32'd0);
      cyc();
      chk("vld_lat1", 32'(sample_vld), 32'd0);
      cyc();
      chk("vld_lat2", 32'(sample_vld), 32'd1);
      chk("unity_passthrough", sample_out, 32'h8000_7FFF);
      repeat (20) begin
         rd_level = LVL_W'($urandom_range(64, 1023));
         cyc();
      end

      // Saturation corner cases, then random gains and gain zero.
      gain = {8'd64, 8'd255};
      src_q.push_back({16'hFFFE, 16'h7000});
      cyc();
      cyc();
      chk("gain_sat", sample_out, 32'hFFFF_7FFF);
      repeat (4) begin
         gain = 16'($urandom);
         repeat (8) cyc();
      end
      gain = '0;
      repeat (4) cyc();
      chk("gain_zero", sample_out, 32'd0);
      gain = {8'd128, 8'd128};
      repeat (4) cyc();

      // Mute keeps draining the FIFO while the output stays silent.
      mute = 1'b1;
      repeat (6) begin
         cyc();
         chk("mute_out", sample_out, 32'd0);
         chk("mute_vld", 32'(sample_vld), 32'd1);
         chk("mute_rden", 32'(rden), 32'd1);
      end
      mute = 1'b0;
      repeat (4) cyc();

      // Underrun: empty FIFO in PLAY, recovery only once the level reaches PREFILL.
      rdempty = 1'b1;
      #1;
      chk("ur_rden", 32'(rden), 32'd0);
      chk("ur_pulse", 32'(underrun), 32'd1);
      chk("ur_state_before", 32'(state), 32'd2);
      cyc(1'b1);
      chk("ur_state", 32'(state), 32'd3);
      chk("ur_pulse_end", 32'(underrun), 32'd0);
      chk("ur_silence", sample_out, 32'd0);
      chk("ur_vld", 32'(sample_vld), 32'd0);
      rdempty  = 1'b0;
      rd_level = LVL_W'(PRE - 1);
      repeat (3) begin
         cyc();
         chk("refill_state", 32'(state), 32'd3);
         chk("refill_rden", 32'(rden), 32'd0);
      end
      rd_level = LVL_W'(PRE);
      cyc();
      chk("resume_state", 32'(state), 32'd2);
      repeat (10) cyc();

      // Disable mid-PLAY.
      enable = 1'b0;
      #1;
      chk("dis_rden", 32'(rden), 32'd0);
      cyc(1'b1);
      chk("dis_state", 32'(state), 32'd0);
      chk("dis_silence", sample_out, 32'd0);
      chk("dis_vld", 32'(sample_vld), 32'd0);
      repeat (2) cyc();

      // Asynchronous reset in the middle of playback.
      enable = 1'b1;
      cyc();
      cyc();
      repeat (5) cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rden", 32'(rden), 32'd0);
      chk("arst_sample_out", sample_out, 32'd0);
      chk("arst_vld", 32'(sample_vld), 32'd0);
      chk("arst_underrun", 32'(underrun), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      exp_q.delete();
      exp_out = '0;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_state", 32'(state), 32'd1);

`ifdef PDM_FEED_STATS_EN
      chk("cnt_after_rst", 32'(underrun_cnt), 32'd0);
      cyc();
      repeat (3) begin
         repeat (2) cyc();
         rdempty = 1'b1;
         cyc(1'b1);
         rdempty = 1'b0;
         cyc();
      end
      chk("cnt_three", 32'(underrun_cnt), 32'd3);
      enable = 1'b0;
      cyc(1'b1);
      chk("cnt_cleared", 32'(underrun_cnt), 32'd0);
`endif

      enable = 1'b0;
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
